// File: rtl/arm_defs.sv
// arm_defs: shared FSM state encoding and default memory-map constants
package arm_defs;

    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_SRAM_AW     = 18;
    localparam int DEF_WAIT_CYCLES = 3;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit word access from MEM as two 16-bit async SRAM accesses plus settle wait
module sram_ctrl
    import arm_defs::*;
#(
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    state_t             state, next_state;
    logic [7:0]         cnt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wd;
    logic [15:0]        rd_lo, rd_hi, dq_out;
    logic               dq_oe;
    logic [31:0]        off;
    logic [SRAM_AW-2:0] req_word;
    logic               unused_off;
    logic               lat_wr;
    logic [SRAM_AW-2:0] lat_word;
    logic [31:0]        lat_wd;
    logic               acc_next;

    // Addresses below BASE_ADDR wrap naturally through the truncation
    assign off        = address - 32'(BASE_ADDR);
    assign req_word   = off[SRAM_AW:2];
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    // In IDLE the request is latched on the same edge that enters ACC_LO, so use it directly
    assign lat_wr   = (state == IDLE) ? wr_en     : op_wr;
    assign lat_word = (state == IDLE) ? req_word  : word;
    assign lat_wd   = (state == IDLE) ? writeData : wd;
    assign acc_next = (next_state == ACC_LO) || (next_state == ACC_HI);

    assign ready     = ~(wr_en | rd_en) | (state == DONE);
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // Next-state sequencing: two halfword accesses, fixed settle wait, one-cycle DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (wr_en | rd_en) ? ACC_LO : IDLE;
            ACC_LO:  next_state = ACC_HI;
            ACC_HI:  next_state = WAIT;
            WAIT:    next_state = (cnt == 8'(WAIT_CYCLES - 1)) ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, wait counter and request latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            op_wr <= 1'b0;
            word  <= '0;
            wd    <= 32'd0;
        end else begin
            state <= next_state;
            cnt   <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && next_state == ACC_LO) begin
                op_wr <= wr_en;
                word  <= req_word;
                wd    <= writeData;
            end
        end
    end

    // SRAM pins registered off next-state so they are stable for the whole access cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= 16'd0;
        end else begin
            SRAM_ADDR <= (next_state == ACC_LO) ? {lat_word, 1'b0} :
                         (next_state == ACC_HI) ? {lat_word, 1'b1} : SRAM_ADDR;
            SRAM_WE_N <= ~(lat_wr & acc_next);
            dq_oe     <= lat_wr & acc_next;
            dq_out    <= (next_state == ACC_HI) ? lat_wd[31:16] : lat_wd[15:0];
        end
    end

    // Read halves captured at the end of each access; word published on DONE entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_lo    <= 16'd0;
            rd_hi    <= 16'd0;
            readData <= 32'd0;
        end else begin
            if (state == ACC_LO && !op_wr) rd_lo <= SRAM_DQ;
            if (state == ACC_HI && !op_wr) rd_hi <= SRAM_DQ;
            if (next_state == DONE && !op_wr) readData <= {rd_hi, rd_lo};
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with a behavioural async SRAM
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [17:0] we_addrs[$];
    logic [31:0] shadow[int];
    logic [31:0] last_rd = 32'd0;

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk = ~clk;

    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

    sram_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    task automatic pop_check(input string name);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, readData=%h", name, readData);
        end else begin
            e = exp_q.pop_front();
            if (readData !== e) begin
                bad++;
                $display("FAIL %s: readData=%h expected=%h", name, readData, e);
            end
            last_rd = e;
        end
    endtask

    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, output int lat);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; writeData = d;
        if (w) shadow[a] = d;
        else if (r) exp_q.push_back(shadow[a]);
        we_addrs.delete();
        lat = 0;
        #1;
        while (ready !== 1'b1 && lat < 50) begin
            if (SRAM_WE_N === 1'b0) we_addrs.push_back(SRAM_ADDR);
            lat++;
            @(negedge clk);
            #1;
        end
        if (lat >= 50) begin
            total++; bad++;
            $display("FAIL access_timeout: ready never rose for address %h", a);
        end else if (r && !w) pop_check("read_data");
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_lat(input string name, input int lat);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL %s: busy cycles=%0d expected=6", name, lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 4;
        if (readData !== 32'd0) begin bad++; $display("FAIL reset_readData: got=%h expected=0", readData); end
        if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b expected=1", ready); end
        if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL reset_we_n: got=%b expected=1", SRAM_WE_N); end
        if (SRAM_ADDR !== 18'd0) begin bad++; $display("FAIL reset_addr: got=%h expected=0", SRAM_ADDR); end
    endtask

    task automatic test_write_read;
        int lat;
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat);
        check_lat("write_latency", lat);
        @(negedge clk);
        total += 2;
        if (mem[0] !== 16'hBEEF) begin bad++; $display("FAIL write_lo: mem0=%h expected=beef", mem[0]); end
        if (mem[1] !== 16'hDEAD) begin bad++; $display("FAIL write_hi: mem1=%h expected=dead", mem[1]); end
        do_access(1'b0, 1'b1, 32'd1024, 32'd0, lat);
        check_lat("read_latency", lat);
    endtask

    task automatic test_addressing;
        int lat;
        do_access(1'b1, 1'b0, 32'd1028, 32'h12345678, lat);
        total++;
        if (we_addrs.size() != 2 || we_addrs[0] !== 18'd2 || we_addrs[1] !== 18'd3) begin
            bad++;
            $display("FAIL write_addr_seq: count=%0d first=%h second=%h expected 2,3",
                     we_addrs.size(), we_addrs.size() > 0 ? we_addrs[0] : 18'h0,
                     we_addrs.size() > 1 ? we_addrs[1] : 18'h0);
        end
        do_access(1'b0, 1'b1, 32'd1024, 32'd0, lat);
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, lat);
    endtask

    task automatic test_simultaneous;
        int lat;
        do_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, lat);
        check_lat("both_latency", lat);
        @(negedge clk);
        total += 3;
        if (readData !== last_rd) begin bad++; $display("FAIL both_readData: got=%h expected=%h", readData, last_rd); end
        if (mem[4] !== 16'h5A5A) begin bad++; $display("FAIL both_lo: mem4=%h expected=5a5a", mem[4]); end
        if (mem[5] !== 16'hA5A5) begin bad++; $display("FAIL both_hi: mem5=%h expected=a5a5", mem[5]); end
        do_access(1'b0, 1'b1, 32'd1032, 32'd0, lat);
    endtask

    task automatic test_drop_request;
        int lat;
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1024;
        exp_q.push_back(shadow[32'd1024]);
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (readData !== last_rd) begin bad++; $display("FAIL drop_early: readData=%h expected=%h", readData, last_rd); end
        @(negedge clk);
        pop_check("drop_done");
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, lat);
        check_lat("after_drop_latency", lat);
    endtask

    task automatic test_reset_abort;
        int lat;
        do_access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, lat);
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; writeData = 32'h11112222;
        repeat (2) @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        total += 3;
        if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL abort_we_n: got=%b expected=1", SRAM_WE_N); end
        if (readData !== 32'd0) begin bad++; $display("FAIL abort_readData: got=%h expected=0", readData); end
        if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got=%b expected=1", ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 2;
        if (mem[8] !== 16'h2222) begin bad++; $display("FAIL abort_lo: mem8=%h expected=2222", mem[8]); end
        if (mem[9] !== 16'hCAFE) begin bad++; $display("FAIL abort_hi: mem9=%h expected=cafe", mem[9]); end
        shadow[32'd1040] = 32'hCAFE2222;
        last_rd = 32'd0;
        do_access(1'b0, 1'b1, 32'd1040, 32'd0, lat);
        check_lat("post_abort_latency", lat);
    endtask

    task automatic test_back_to_back;
        int done = 0;
        int first = -1;
        int second = -1;
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1024;
        exp_q.push_back(shadow[32'd1024]);
        #1;
        for (int i = 0; i < 30 && done < 2; i++) begin
            if (ready === 1'b1) begin
                done++;
                pop_check("b2b_data");
                if (done == 1) begin
                    first = i;
                    address = 32'd1028;
                    exp_q.push_back(shadow[32'd1028]);
                end else begin
                    second = i;
                    rd_en = 1'b0;
                end
            end
            @(negedge clk);
            #1;
        end
        rd_en = 1'b0;
        total += 3;
        if (done != 2) begin bad++; $display("FAIL b2b_count: completions=%0d expected=2", done); end
        if (first != 6) begin bad++; $display("FAIL b2b_first: ready at=%0d expected=6", first); end
        if (second - first != 7) begin bad++; $display("FAIL b2b_period: gap=%0d expected=7", second - first); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_addressing;
        test_simultaneous;
        test_drop_request;
        test_reset_abort;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
